// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver with a serial double-dabble
// binary-to-BCD converter, signed/hex display, blanking and overflow flag.
//
// Ports:
//   clk, rst      board clock, synchronous active-high reset
//   value         number to display (DATA_W bits)
//   load          capture strobe, taken only while busy=0
//   hex_mode      1 = hex, 0 = decimal (sampled with load)
//   signed_mode   1 = two's complement decimal (sampled with load)
//   busy          conversion in progress
//   ovf           displayed value does not fit in DIGITS
//   an            one-hot digit enable
//   seg           segments {g,f,e,d,c,b,a}
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              signed_mode,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = 4 * DIGITS;

  localparam logic [6:0] G_ZERO  = 7'b0111111;
  localparam logic [6:0] G_DASH  = 7'b1000000;
  localparam logic [6:0] G_BLANK = 7'b0000000;

  localparam logic [DIGITS-1:0] AN0 = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_RST = ACTIVE_LOW ? ~AN0 : AN0;
  localparam logic [6:0] SEG_RST = ACTIVE_LOW ? ~G_ZERO : G_ZERO;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [39:0]       bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [NW-1:0]     disp_q, disp_d;
  logic              dneg_q, dneg_d;
  logic              dhex_q, dhex_d;
  logic              ovf_q, ovf_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [39:0]          bcd_adj;
  logic [NW+DATA_W-1:0] val_ext;
  int                   done_k;
  int                   disp_k;
  int                   idx_i;
  logic [3:0]           nib;
  logic [6:0]           seg_hi;
  logic [DIGITS-1:0]    an_hi;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1101111;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b1111100;
      4'hC:    g = 7'b0111001;
      4'hD:    g = 7'b1011110;
      4'hE:    g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

  // Converter FSM and display buffer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    disp_d  = disp_q;
    dneg_d  = dneg_q;
    dhex_d  = dhex_q;
    ovf_d   = ovf_q;
    val_ext = {{NW{1'b0}}, value};
    bcd_adj = bcd_q;
    done_k  = 1;

    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      if (bcd_q[4*i +: 4] != 4'd0)
        done_k = i + 1;
    end

    case (state_q)
      S_IDLE: begin
        if (load && hex_mode) begin
          disp_d = val_ext[NW-1:0];
          dneg_d = 1'b0;
          dhex_d = 1'b1;
          ovf_d  = 1'b0;
        end else if (load) begin
          if (signed_mode && value[DATA_W-1]) begin
            mag_d = ~value + DATA_W'(1);
            neg_d = 1'b1;
          end else begin
            mag_d = value;
            neg_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = CW'(DATA_W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = bcd_q[NW-1:0];
        dneg_d  = neg_q;
        dhex_d  = 1'b0;
        // A minus sign needs one extra digit position
        ovf_d   = (done_k > DIGITS) ||
                  (neg_q && (done_k > DIGITS - 1));
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Scan counter, glyph selection and registered outputs
  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    idx_d  = idx_q;
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      if (idx_q == IW'(DIGITS - 1))
        idx_d = '0;
      else
        idx_d = idx_q + IW'(1);
    end

    disp_k = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'd0)
        disp_k = i + 1;
    end

    idx_i = int'(idx_q);
    nib   = disp_q[4*idx_i +: 4];

    if (ovf_q)
      seg_hi = G_DASH;
    else if (dhex_q)
      seg_hi = glyph(nib);
    else if (idx_i == 0 || idx_i < disp_k)
      seg_hi = glyph(nib);
    else if (dneg_q && idx_i == disp_k)
      seg_hi = G_DASH;
    else
      seg_hi = G_BLANK;

    an_hi        = '0;
    an_hi[idx_q] = 1'b1;

    an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      disp_q  <= '0;
      dneg_q  <= 1'b0;
      dhex_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rcnt_q  <= '0;
      idx_q   <= '0;
      an_q    <= AN_RST;
      seg_q   <= SEG_RST;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      disp_q  <= disp_d;
      dneg_q  <= dneg_d;
      dhex_q  <= dhex_d;
      ovf_q   <= ovf_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: table of load vectors with
// hand-computed glyphs, plus scan, handshake and mid-conversion reset.
`timescale 1ns/1ps
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic        signed_mode;
  logic        busy;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks;
  int errors;

  ssd_scan_driver #(
    .DIGITS(4),
    .DATA_W(16),
    .REFRESH_DIV(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .load(load),
    .hex_mode(hex_mode),
    .signed_mode(signed_mode),
    .busy(busy),
    .ovf(ovf),
    .an(an),
    .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low glyphs
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_7 = 7'b1111000;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_9 = 7'b0010000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_B = 7'b0000011;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_F = 7'b0001110;
  localparam logic [6:0] S_M = 7'b0111111;
  localparam logic [6:0] S_X = 7'b1111111;

  typedef struct {
    string       name;
    logic [15:0] v;
    logic        hex;
    logic        sgn;
    int          nbusy;
    logic        ovf;
    logic [6:0]  s3;
    logic [6:0]  s2;
    logic [6:0]  s1;
    logic [6:0]  s0;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_digit(input int d, output logic [6:0] s);
    logic [3:0] want;
    logic       found;
    want  = 4'b0001 << d;
    want  = ~want;
    found = 1'b0;
    s     = 7'bx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (an == want) begin
        s     = seg;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: digit %0d never selected", d);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic hx,
                         input logic sg, output int nb);
    @(negedge clk);
    value       = v;
    hex_mode    = hx;
    signed_mode = sg;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb   = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic check_display(input string name,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] s;
    read_digit(0, s);
    check({name, ".d0"}, 32'(s), 32'(e0));
    read_digit(1, s);
    check({name, ".d1"}, 32'(s), 32'(e1));
    read_digit(2, s);
    check({name, ".d2"}, 32'(s), 32'(e2));
    read_digit(3, s);
    check({name, ".d3"}, 32'(s), 32'(e3));
  endtask

  initial begin
    int         nb;
    int         dg;
    logic [3:0] ea;
    logic [6:0] s;

    checks = 0;
    errors = 0;

    vecs[0]  = '{"dec1234", 16'd1234, 0, 0, 17, 0, S_1, S_2, S_3, S_4};
    vecs[1]  = '{"neg5", 16'hFFFB, 0, 1, 17, 0, S_X, S_X, S_M, S_5};
    vecs[2]  = '{"min_neg", 16'h8000, 0, 1, 17, 1, S_M, S_M, S_M, S_M};
    vecs[3]  = '{"dec12345", 16'd12345, 0, 0, 17, 1, S_M, S_M, S_M, S_M};
    vecs[4]  = '{"neg978", 16'hFC2E, 0, 1, 17, 0, S_M, S_9, S_7, S_8};
    vecs[5]  = '{"neg1000", 16'hFC18, 0, 1, 17, 1, S_M, S_M, S_M, S_M};
    vecs[6]  = '{"hexBEEF", 16'hBEEF, 1, 0, 0, 0, S_B, S_E, S_E, S_F};
    vecs[7]  = '{"hex000A", 16'h000A, 1, 0, 0, 0, S_0, S_0, S_0, S_A};
    vecs[8]  = '{"dec0", 16'd0, 0, 0, 17, 0, S_X, S_X, S_X, S_0};
    vecs[9]  = '{"pos80", 16'd80, 0, 1, 17, 0, S_X, S_X, S_8, S_0};
    vecs[10] = '{"hexsgn", 16'hFFFB, 1, 1, 0, 0, S_F, S_F, S_F, S_B};

    rst         = 1'b1;
    value       = '0;
    load        = 1'b0;
    hex_mode    = 1'b0;
    signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst.an", 32'(an), 32'(4'b1110));
    check("rst.seg", 32'(seg), 32'(S_0));
    check("rst.busy", 32'(busy), 32'(0));
    check("rst.ovf", 32'(ovf), 32'(0));

    // Digit select lags the index by one register stage
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      dg = ((t - 1) / 4) % 4;
      ea = 4'b0001 << dg;
      ea = ~ea;
      check($sformatf("scan.an[%0d]", t), 32'(an), 32'(ea));
      check($sformatf("scan.seg[%0d]", t), 32'(seg),
            32'((dg == 0) ? S_0 : S_X));
    end

    foreach (vecs[i]) begin
      do_load(vecs[i].v, vecs[i].hex, vecs[i].sgn, nb);
      check({vecs[i].name, ".busy"}, 32'(nb), 32'(vecs[i].nbusy));
      repeat (2) @(negedge clk);
      check({vecs[i].name, ".ovf"}, 32'(ovf), 32'(vecs[i].ovf));
      check_display(vecs[i].name, vecs[i].s3, vecs[i].s2,
                    vecs[i].s1, vecs[i].s0);
    end

    // Load during conversion must be ignored
    @(negedge clk);
    value       = 16'd9999;
    hex_mode    = 1'b0;
    signed_mode = 1'b0;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb   = 0;
    while (busy && nb < 40) begin
      nb++;
      if (nb == 3) begin
        value       = 16'd42;
        hex_mode    = 1'b1;
        signed_mode = 1'b1;
        load        = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("hs.busy", 32'(nb), 32'd17);
    @(negedge clk);
    check("hs.busy_after", 32'(busy), 32'(0));
    check("hs.ovf", 32'(ovf), 32'(0));
    check_display("hs", S_9, S_9, S_9, S_9);

    // Reset in the middle of a conversion, old overflow shown meanwhile
    do_load(16'd12345, 1'b0, 1'b0, nb);
    repeat (2) @(negedge clk);
    @(negedge clk);
    value       = 16'd1234;
    hex_mode    = 1'b0;
    signed_mode = 1'b0;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("mid.busy", 32'(busy), 32'(1));
    check("mid.ovf_held", 32'(ovf), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2.busy", 32'(busy), 32'(0));
    check("rst2.ovf", 32'(ovf), 32'(0));
    check("rst2.an", 32'(an), 32'(4'b1110));
    check("rst2.seg", 32'(seg), 32'(S_0));
    repeat (20) @(negedge clk);
    check("rst2.idle", 32'(busy), 32'(0));
    check_display("rst2", S_X, S_X, S_X, S_0);
    read_digit(0, s);
    check("rst2.d0_again", 32'(s), 32'(S_0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
